// File: rtl/index_decoder.sv
// Stream of binary lane indices expanded into a registered pending mask with per-lane retire.
// Optional sticky out-of-range flag: define INDEX_DECODER_RANGE_CHECK_EN.
module index_decoder #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] s_index,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] m_ack,
    output logic [WIDTH-1:0] pending,
    output logic             pending_any,
    output logic [CNT_W-1:0] pending_count,
    output logic [WIDTH-1:0] last_onehot,
    output logic             last_strobe,
    output logic             err_range
);

    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] pend_next;
    logic [CNT_W-1:0] count_next;
    logic             in_range;
    logic             accept;

    // Indices past the top lane shift out entirely, leaving an all-zero one-hot.
    assign onehot   = WIDTH'(1) << s_index;
    assign in_range = |onehot;
    assign s_ready  = !rst && ((onehot & pending) == '0);
    assign accept   = s_valid && s_ready;

    always_comb begin
        pend_next = pending & ~m_ack;
        if (accept) begin
            pend_next = pend_next | onehot;
        end
        count_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_next = count_next + CNT_W'(pend_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            pending_any   <= 1'b0;
            pending_count <= '0;
            last_onehot   <= '0;
            last_strobe   <= 1'b0;
        end else begin
            pending       <= pend_next;
            pending_any   <= |pend_next;
            pending_count <= count_next;
            last_strobe   <= accept && in_range;
            if (accept && in_range) begin
                last_onehot <= onehot;
            end
        end
    end

`ifdef INDEX_DECODER_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_range <= 1'b0;
        end else if (accept && !in_range) begin
            err_range <= 1'b1;
        end
    end
`else
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_index_decoder.sv
// Randomized scoreboard bench for index_decoder (WIDTH=5, so out-of-range indices exist).
module tb_index_decoder;
    localparam int W  = 5;
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] s_index;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  m_ack;
    logic [W-1:0]  pending;
    logic          pending_any;
    logic [CW-1:0] pending_count;
    logic [W-1:0]  last_onehot;
    logic          last_strobe;
    logic          err_range;

    index_decoder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .s_index(s_index), .s_valid(s_valid),
        .s_ready(s_ready), .m_ack(m_ack), .pending(pending),
        .pending_any(pending_any), .pending_count(pending_count),
        .last_onehot(last_onehot), .last_strobe(last_strobe),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference state: a set of pending lanes plus last-accept bookkeeping.
    bit         lane_busy[W];
    bit         exp_strobe;
    bit         exp_err;
    bit         model_known = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] busy_vec();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) v[i] = lane_busy[i];
        return v;
    endfunction

    function automatic int busy_cnt();
        int n = 0;
        for (int i = 0; i < W; i++) n += lane_busy[i];
        return n;
    endfunction

    task automatic cycle(input bit r, input bit v, input int idx, input logic [W-1:0] ack);
        bit exp_ready;
        bit acc;
        logic [W-1:0] oh;
        rst = r;
        s_valid = v;
        s_index = IW'(idx);
        m_ack = ack;
        @(negedge clk);
        exp_ready = !r && (idx >= W || !lane_busy[idx]);
        check("s_ready", longint'(s_ready), longint'(exp_ready));
        if (model_known) begin
            check("pending", longint'(pending), longint'(busy_vec()));
            check("pending_any", longint'(pending_any), longint'(busy_cnt() != 0));
            check("pending_count", longint'(pending_count), longint'(busy_cnt()));
            check("last_strobe", longint'(last_strobe), longint'(exp_strobe));
            check("err_range", longint'(err_range), longint'(exp_err));
        end
        acc = v && exp_ready;
        oh = '0;
        if (acc && idx < W) begin
            oh[idx] = 1'b1;
            exp_q.push_back(oh);
        end
        @(posedge clk);
        if (r) begin
            foreach (lane_busy[i]) lane_busy[i] = 0;
            exp_strobe = 0;
            exp_err = 0;
            model_known = 1;
        end else begin
            for (int i = 0; i < W; i++) if (ack[i]) lane_busy[i] = 0;
            exp_strobe = acc && idx < W;
            if (exp_strobe) lane_busy[idx] = 1;
`ifdef INDEX_DECODER_RANGE_CHECK_EN
            if (acc && idx >= W) exp_err = 1;
`endif
        end
        #1;
    endtask

    // Monitor: every strobe must match the oldest outstanding accept.
    always @(negedge clk) begin
        if (last_strobe === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL last_onehot: strobe %0h with no accept queued", last_onehot);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (last_onehot !== e) begin
                    bad++;
                    $display("FAIL last_onehot: got %0h expected %0h", last_onehot, e);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles while an index is offered.
        cycle(1, 1, 2, '0);
        cycle(1, 1, 2, '0);
        cycle(0, 1, 2, '0);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, 5'b00100);
        // Back-to-back accepts, duplicate stall, then ack releases it.
        cycle(0, 1, 0, '0);
        cycle(0, 1, 1, '0);
        cycle(0, 1, 3, '0);
        cycle(0, 1, 1, '0);
        cycle(0, 1, 1, 5'b00010);
        cycle(0, 1, 1, '0);
        cycle(0, 0, 0, 5'b01011);
        // Accept plus acks on other lanes in the same cycle.
        cycle(0, 1, 0, '0);
        cycle(0, 1, 2, '0);
        cycle(0, 1, 1, 5'b00101);
        cycle(0, 0, 0, 5'b00010);
        // Fill, stall every in-range index, out-of-range still taken, drain.
        for (int i = 0; i < W; i++) cycle(0, 1, i, '0);
        for (int i = 0; i < 8; i++) cycle(0, 1, i, '0);
        cycle(0, 0, 0, '1);
        // Ack of idle lanes is ignored.
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, 5'b11110);
        cycle(0, 1, 6, 5'b00001);
        cycle(0, 0, 0, '0);
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] a;
            a = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, (1 << IW) - 1), a);
        end
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/index_decoder.md
Name: index_decoder

Overview:
- Sequential counterpart of the priority encoder: accepts a stream of binary indices over a valid/ready handshake and expands each index to one-hot form.
- Accumulates indices into a registered pending bitmask. Downstream logic retires bits individually by per-bit acknowledge.
- Used to rebuild request vectors from encoded request streams, e.g. in arbiter/mux return paths.

Parameters:
- WIDTH, 4, number of lanes (bits of pending mask); any value >= 2, not necessarily a power of two.
- IDX_W, $clog2(WIDTH), index width. Derived; must not be overridden.
- CNT_W, $clog2(WIDTH+1), width of the pending-bit counter. Derived.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- s_index  input  IDX_W  encoded lane index.
- s_valid  input  1  s_index valid.
- s_ready  output  1  index can be accepted this cycle.
- m_ack  input  WIDTH  per-lane retire strobe; clears the matching pending bit.
- pending  output  WIDTH  registered pending mask.
- pending_any  output  1  registered, equals |pending.
- pending_count  output  CNT_W  registered population count of pending.
- last_onehot  output  WIDTH  one-hot of the last accepted in-range index; held until the next accept.
- last_strobe  output  1  one-cycle pulse, cycle after an accept.
- err_range  output  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
Reset:
- rst high at a clock edge: pending=0, pending_any=0, pending_count=0, last_onehot=0, last_strobe=0, err_range=0.
- Reset overrides any same-cycle accept or ack.
- The index held on s_index during reset is never recorded.

Handshake:
- Accept occurs when s_valid && s_ready.
- s_ready is combinational: 1 if s_index >= WIDTH; else !pending[s_index]. A duplicate index therefore stalls until that lane is acked.
- s_ready is 0 while rst is high.
- s_valid may toggle freely. Data is sampled only on accept.

Set/clear:
- An in-range accept sets pending[s_index] at the next edge. Latency 1 cycle.
- m_ack[i] clears pending[i] at the next edge. m_ack on a lane that is not pending is ignored.
- Accept and acks on different lanes in the same cycle all take effect.
- Accept and ack on the same lane in the same cycle is impossible: the accept requires that bit to be clear, and ack on a clear bit is ignored.

Counter:
- next pending_count = pending_count + (in-range accept) - popcount(m_ack & pending).
- Maximum value is WIDTH. No wrap is possible.
- pending_any and pending_count are registered together with pending, so all three are always mutually consistent.

Last-index outputs:
- On an in-range accept: last_onehot <= 1 << s_index, and last_strobe <= 1 for exactly one cycle.
- Otherwise last_strobe <= 0 and last_onehot holds its value.
- Back-to-back accepts give last_strobe high on consecutive cycles.

Full/empty:
- All lanes pending: every in-range index stalls; out-of-range indices are still accepted.
- pending == 0: pending_any = 0 and pending_count = 0.

Out-of-range:
- An index >= WIDTH is only possible when WIDTH is not a power of two.
- Such an index is always accepted and dropped: no change to pending, counter, last_onehot or last_strobe.

Optional Feature:
- Macro: INDEX_DECODER_RANGE_CHECK_EN.
- Defined: an accepted out-of-range index sets err_range at the next edge. err_range stays set until rst.
- Undefined: err_range is tied to 0 and the compare logic is not synthesized. Out-of-range indices are still silently accepted and dropped.

Test Plan:
- Reset sequence, WIDTH=4: drive rst high 2 cycles with s_valid=1, s_index=2 -> pending=0, count=0, last_strobe=0, s_ready=0 throughout; first cycle after rst low: accept, then pending=4'b0100, count=1, last_onehot=4'b0100, last_strobe pulses once.
- Accept 0,1,3 on consecutive cycles, WIDTH=4 -> pending=4'b1011, count=3, last_strobe high 3 consecutive cycles; then s_index=1 -> s_ready=0; m_ack=4'b0010 -> next cycle s_ready=1 and the stalled index is accepted the following edge.
- Simultaneous events: pending=4'b0101; accept index 1 with m_ack=4'b0101 in the same cycle -> pending=4'b0010, count=1.
- Full: fill all 4 lanes -> count=4, s_ready=0 for every in-range index; m_ack=4'b1111 -> pending=0, pending_any=0, count=0.
- Out-of-range, WIDTH=5: s_index=6 with macro defined -> s_ready=1, pending unchanged, last_strobe=0, err_range=1 and held; rebuilt without the macro -> err_range stays 0.
- Ack of non-pending lanes: pending=5'b00001, m_ack=5'b11110 -> pending and count unchanged.
